update8_arb: RTL and testbench

UPDATE8_ARB -- requirements
Module: update8_arb

---
 rtl/update8_arb.sv | 200 ++++++++++++++++++++
 tb/tb_update8_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/update8_arb.sv
`timescale 1ns/1ps
// update8_arb: two-requester byte arbiter in front of an update8 hash engine.
// One byte is in flight at a time: it is accepted from the granted requester,
// fed to the engine, and the engine hash is returned with requester id,
// last flag and the 1-based byte index within the packet.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid_i/byte_i/last_i   per-requester byte stream (requester i in
//   req_ready_o                 bits [i*IN_DW +: IN_DW] of req_byte_i)
//   eng_start_o                 one-cycle start pulse per byte
//   eng_byte_o/in_valid_o/      byte handshake to the engine
//   eng_in_ready_i
//   eng_out_valid_i/h0_i/       hash handshake from the engine
//   eng_out_ready_o
//   out_valid_o/h0_o/id_o/      result handshake
//   last_o/cnt_o/out_ready_i
//   err_o                       sticky engine timeout flag
module update8_arb #(
    parameter int IN_DW   = 8,
    parameter int H0_DW   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid_i,
    input  logic [2*IN_DW-1:0] req_byte_i,
    input  logic [1:0]         req_last_i,
    output logic [1:0]         req_ready_o,
    output logic               eng_start_o,
    output logic [IN_DW-1:0]   eng_byte_o,
    output logic               eng_in_valid_o,
    input  logic               eng_in_ready_i,
    input  logic               eng_out_valid_i,
    input  logic [H0_DW-1:0]   eng_h0_i,
    output logic               eng_out_ready_o,
    output logic               out_valid_o,
    output logic [H0_DW-1:0]   out_h0_o,
    output logic               out_id_o,
    output logic               out_last_o,
    output logic [15:0]        out_cnt_o,
    input  logic               out_ready_i,
    output logic               err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_DLVR
    } state_e;

    state_e             state_q, state_d;
    logic [IN_DW-1:0]   byte_q, byte_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic               lock_q, lock_d;
    logic               rr_q, rr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [H0_DW-1:0]   h0_q, h0_d;
    logic               err_q, err_d;

    logic               gnt;
    logic [IN_DW-1:0]   gnt_byte;
    logic [1:0]         rdy;
    logic               timeout;

    // Open packet pins the grant; otherwise the single valid requester wins,
    // and on contention the one not served last (rr_q holds last served).
    always_comb begin
        gnt = 1'b0;
        if (lock_q) begin
            gnt = id_q;
        end else if (req_valid_i == 2'b11) begin
            gnt = ~rr_q;
        end else begin
            gnt = req_valid_i[1];
        end
    end

    assign gnt_byte = gnt ? req_byte_i[2*IN_DW-1 -: IN_DW]
                          : req_byte_i[IN_DW-1:0];

    // Timer holds the number of FEED/WAIT cycles already spent on this byte.
    assign timeout = (timer_q >= TMAX);

    always_comb begin
        state_d         = state_q;
        byte_d          = byte_q;
        last_d          = last_q;
        id_d            = id_q;
        lock_d          = lock_q;
        rr_d            = rr_q;
        cnt_d           = cnt_q;
        timer_d         = timer_q;
        h0_d            = h0_q;
        err_d           = err_q;
        rdy             = 2'b00;
        eng_start_o     = 1'b0;
        eng_in_valid_o  = 1'b0;
        eng_byte_o      = '0;
        eng_out_ready_o = 1'b0;
        out_valid_o     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rdy[gnt] = req_valid_i[gnt];
                if (req_valid_i[gnt]) begin
                    byte_d  = gnt_byte;
                    last_d  = req_last_i[gnt];
                    id_d    = gnt;
                    lock_d  = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    timer_d = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                eng_start_o = 1'b1;
                state_d     = S_FEED;
            end
            S_FEED: begin
                eng_in_valid_o = 1'b1;
                eng_byte_o     = byte_q;
                timer_d        = timer_q + 1'b1;
                if (eng_in_ready_i) begin
                    state_d = S_WAIT;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                eng_out_ready_o = 1'b1;
                timer_d         = timer_q + 1'b1;
                if (eng_out_valid_i) begin
                    h0_d    = eng_h0_i;
                    state_d = S_DLVR;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_DLVR: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                    if (last_q) begin
                        lock_d = 1'b0;
                        rr_d   = id_q;
                        cnt_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            last_q  <= 1'b0;
            id_q    <= 1'b0;
            lock_q  <= 1'b0;
            rr_q    <= 1'b1;
            cnt_q   <= '0;
            timer_q <= '0;
            h0_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            id_q    <= id_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            h0_q    <= h0_d;
            err_q   <= err_d;
        end
    end

    // IDLE ready is a pass-through of req_valid; mask it so reset is quiet.
    assign req_ready_o = rdy & {2{rst_n}};
    assign out_h0_o    = h0_q;
    assign out_id_o    = id_q;
    assign out_last_o  = last_q;
    assign out_cnt_o   = cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_update8_arb.sv
`timescale 1ns/1ps
// tb_update8_arb: directed bench for update8_arb with a behavioural engine
// stub whose hash is {byte, 24'h001234}.
module tb_update8_arb;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_byte;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        eng_start;
    logic [7:0]  eng_byte;
    logic        eng_in_valid;
    logic        eng_in_ready;
    logic        eng_out_valid;
    logic [31:0] eng_h0;
    logic        eng_out_ready;
    logic        out_valid;
    logic [31:0] out_h0;
    logic        out_id;
    logic        out_last;
    logic [15:0] out_cnt;
    logic        out_ready;
    logic        err;

    update8_arb #(.IN_DW(8), .H0_DW(32), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid),
        .req_byte_i      (req_byte),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .eng_start_o     (eng_start),
        .eng_byte_o      (eng_byte),
        .eng_in_valid_o  (eng_in_valid),
        .eng_in_ready_i  (eng_in_ready),
        .eng_out_valid_i (eng_out_valid),
        .eng_h0_i        (eng_h0),
        .eng_out_ready_o (eng_out_ready),
        .out_valid_o     (out_valid),
        .out_h0_o        (out_h0),
        .out_id_o        (out_id),
        .out_last_o      (out_last),
        .out_cnt_o       (out_cnt),
        .out_ready_i     (out_ready),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    // Engine stub: accepts after feed_hold stalled FEED cycles, answers
    // stub_dly cycles into WAIT, never answers while stub_dead is set.
    int         stub_dly;
    int         feed_hold;
    logic       stub_dead;
    logic       stub_pend;
    int         stub_cnt;
    int         feed_n;
    logic [7:0] stub_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_pend <= 1'b0;
            stub_cnt  <= 0;
            stub_b    <= 8'h00;
            feed_n    <= 0;
        end else begin
            feed_n <= (eng_in_valid && !eng_in_ready) ? feed_n + 1 : 0;
            if (eng_in_valid && eng_in_ready) begin
                stub_pend <= 1'b1;
                stub_b    <= eng_byte;
                stub_cnt  <= stub_dly;
            end else if (eng_out_valid && eng_out_ready) begin
                stub_pend <= 1'b0;
            end else if (stub_pend && stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    assign eng_in_ready  = (feed_n >= feed_hold);
    assign eng_out_valid = stub_pend && (stub_cnt == 0) && !stub_dead;
    assign eng_h0        = {stub_b, 24'h001234};

    int   outs = 0;
    int   starts = 0;
    int   viol = 0;
    logic forbid0 = 1'b0;
    logic forbid1 = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) outs <= outs + 1;
        if (eng_start) starts <= starts + 1;
        if ((forbid0 && req_ready[0]) || (forbid1 && req_ready[1]))
            viol <= viol + 1;
    end

    int pass_cnt = 0;
    int tot_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Call from posedge+#1 so ready is sampled in the arbitrating cycle.
    task automatic send(input logic id, input logic [7:0] b,
                        input logic last);
        int n;
        req_valid[id] = 1'b1;
        req_byte[int'(id)*8 +: 8] = b;
        req_last[id] = last;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("grant_r%0d_%0h", id, b), 32'(req_ready[id]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        req_last[id] = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic id,
                              input logic [15:0] cnt, input logic last,
                              input logic [31:0] h0, output int lat);
        int n;
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_h0"}, out_h0, h0);
        chk({nm, "_id"}, 32'(out_id), 32'(id));
        chk({nm, "_cnt"}, 32'(out_cnt), 32'(cnt));
        chk({nm, "_last"}, 32'(out_last), 32'(last));
        lat = n;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        id;
        logic [7:0]  b;
        logic        last;
        int          dly;
        int          hold;
        logic [31:0] h0;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          s0;
        int          n;
        int          snap;
        logic        ok;
        logic [15:0] wcnt[4];

        vt[0] = '{1'b0, 8'h00, 1'b1, 0, 0, 32'h0000_1234, 16'd1};
        vt[1] = '{1'b1, 8'hA5, 1'b0, 2, 0, 32'hA500_1234, 16'd1};
        vt[2] = '{1'b1, 8'h3C, 1'b0, 0, 3, 32'h3C00_1234, 16'd2};
        vt[3] = '{1'b1, 8'hFF, 1'b1, 5, 0, 32'hFF00_1234, 16'd3};
        vt[4] = '{1'b0, 8'h81, 1'b0, 1, 0, 32'h8100_1234, 16'd1};
        vt[5] = '{1'b0, 8'h7E, 1'b1, 3, 1, 32'h7E00_1234, 16'd2};
        wcnt[0] = 16'hFFFE;
        wcnt[1] = 16'hFFFF;
        wcnt[2] = 16'h0000;
        wcnt[3] = 16'h0001;

        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_byte  = 16'h0000;
        req_last  = 2'b00;
        out_ready = 1'b1;
        stub_dly  = 0;
        feed_hold = 0;
        stub_dead = 1'b0;
        #2;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_eng", {eng_start, eng_in_valid, eng_out_ready, eng_byte},
            32'd0);
        chk("rst_out", {out_valid, out_id, out_last, out_cnt}, 32'd0);
        chk("rst_h0_err", out_h0 | 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: requester 0 first, whole packet before requester 1.
        forbid1 = 1'b1;
        req_valid[1] = 1'b1;
        req_byte[15:8] = 8'h20;
        req_last[1] = 1'b0;
        send(1'b0, 8'h10, 1'b0);
        expect_out("c0", 1'b0, 16'd1, 1'b0, 32'h1000_1234, lat);
        send(1'b0, 8'h11, 1'b1);
        expect_out("c1", 1'b0, 16'd2, 1'b1, 32'h1100_1234, lat);
        forbid1 = 1'b0;
        send(1'b1, 8'h20, 1'b0);
        expect_out("c2", 1'b1, 16'd1, 1'b0, 32'h2000_1234, lat);
        send(1'b1, 8'h21, 1'b1);
        expect_out("c3", 1'b1, 16'd2, 1'b1, 32'h2100_1234, lat);

        // Table: handshake -> out_valid is START, FEED(+stall), WAIT(+dly),
        // then DELIVER: 4 + hold + dly cycles.
        for (int i = 0; i < 6; i++) begin
            stub_dly  = vt[i].dly;
            feed_hold = vt[i].hold;
            s0 = starts;
            send(vt[i].id, vt[i].b, vt[i].last);
            expect_out($sformatf("v%0d", i), vt[i].id, vt[i].cnt,
                       vt[i].last, vt[i].h0, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat),
                32'(4 + vt[i].dly + vt[i].hold));
            chk($sformatf("v%0d_starts", i), 32'(starts - s0), 32'd1);
        end
        stub_dly  = 0;
        feed_hold = 0;

        // Output stall with a second requester waiting.
        out_ready = 1'b0;
        send(1'b0, 8'h99, 1'b1);
        req_valid[1] = 1'b1;
        req_byte[15:8] = 8'h55;
        req_last[1] = 1'b1;
        expect_out("st", 1'b0, 16'd1, 1'b1, 32'h9900_1234, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok = out_valid && (out_h0 == 32'h9900_1234) && !out_id &&
                 (out_cnt == 16'd1) && out_last && (req_ready == 2'b00) &&
                 !eng_start;
            chk($sformatf("stall_c%0d", i), 32'(ok), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 8'h55, 1'b1);
        expect_out("st2", 1'b1, 16'd1, 1'b1, 32'h5500_1234, lat);

        // Engine never answers: START, TO FEED/WAIT cycles, then err.
        stub_dead = 1'b1;
        snap = outs;
        send(1'b0, 8'h42, 1'b0);
        @(negedge clk);
        chk("to_start", 32'(eng_start), 32'd1);
        n = 0;
        while (!err && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_delay", 32'(n), 32'(TO + 1));
        repeat (3) @(negedge clk);
        chk("to_no_out", 32'(outs - snap), 32'd0);
        stub_dead = 1'b0;
        @(posedge clk);
        #1;
        send(1'b1, 8'h77, 1'b1);
        expect_out("to_next", 1'b1, 16'd1, 1'b1, 32'h7700_1234, lat);
        chk("to_err_sticky", 32'(err), 32'd1);

        // Reset in WAIT after requester 0 was served last.
        send(1'b0, 8'h0A, 1'b1);
        expect_out("pre_rst", 1'b0, 16'd1, 1'b1, 32'h0A00_1234, lat);
        stub_dly = 30;
        send(1'b1, 8'hB0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!eng_out_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rst_in_wait", 32'(eng_out_ready), 32'd1);
        snap = outs;
        req_valid = 2'b11;
        req_byte  = 16'hD2C1;
        req_last  = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'd0);
        chk("mrst_eng", {eng_start, eng_in_valid, eng_out_ready, eng_byte},
            32'd0);
        chk("mrst_out", {out_valid, out_id, out_last, out_cnt}, 32'd0);
        chk("mrst_h0", out_h0, 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        stub_dly = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_first_gnt", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        req_last[0] = 1'b0;
        expect_out("mrst_a", 1'b0, 16'd1, 1'b1, 32'hC100_1234, lat);
        send(1'b1, 8'hD2, 1'b1);
        expect_out("mrst_b", 1'b1, 16'd1, 1'b1, 32'hD200_1234, lat);
        chk("mrst_outs", 32'(outs - snap), 32'd2);

        // Counter wrap inside one requester-1 packet; requester 0 waits.
        send(1'b1, 8'h01, 1'b0);
        expect_out("w0", 1'b1, 16'd1, 1'b0, 32'h0100_1234, lat);
        force dut.cnt_q = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        forbid0 = 1'b1;
        req_valid[0] = 1'b1;
        req_byte[7:0] = 8'hEE;
        req_last[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(1'b1, 8'(8'h10 + k), k == 3);
            expect_out($sformatf("wrap%0d", k), 1'b1, wcnt[k], k == 3,
                       {8'(8'h10 + k), 24'h001234}, lat);
        end
        forbid0 = 1'b0;
        send(1'b0, 8'hEE, 1'b1);
        expect_out("w_after", 1'b0, 16'd1, 1'b1, 32'hEE00_1234, lat);
        @(negedge clk);
        chk("no_cross_grant", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
